w_ptr_full: RTL and testbench

- Write-side pointer and status controller for the async FIFO.
- Counterpart of the read-pointer/empty block. Runs entirely in the write clock domain.
- Consumes the read pointer (Gray) after it has been synchronized into the write domain. Produces the write Gray pointer sent to the read domain, the binary memory write address and the memory write enable.
- Also produces the full and almost-full flags, a fill level, and overflow diagnostics.

---
 rtl/w_ptr_full.sv | 86 ++++++++
 tb/tb_w_ptr_full.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/w_ptr_full.sv
// Write-domain half of the async FIFO pointer logic: Gray/binary write pointer,
// full and almost-full flags, fill level and overflow diagnostics.
module w_ptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int DROP_W     = 8
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH:0]   w_q2_rptr,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH:0]   w_ptr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  w_we,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam logic [ADDR_WIDTH:0] AF_LEVEL  = (ADDR_WIDTH+1)'(AF_THRESH);
  // One full lap ahead of the read pointer shows up in Gray code as the top
  // two bits inverted and the rest equal.
  localparam logic [ADDR_WIDTH:0] FULL_MASK = {2'b11, {(ADDR_WIDTH-1){1'b0}}};
  localparam logic [DROP_W-1:0]   DROP_ONE  = {{(DROP_W-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] w_bin;
  logic [ADDR_WIDTH:0] bin_next;
  logic [ADDR_WIDTH:0] gray_next;
  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] level_next;
  logic                full_next;
  logic                blocked;

  assign w_we       = w_en & ~full;
  assign blocked    = w_en & full;
  assign w_addr     = w_bin[ADDR_WIDTH-1:0];
  assign bin_next   = w_bin + {{ADDR_WIDTH{1'b0}}, w_we};
  assign gray_next  = (bin_next >> 1) ^ bin_next;
  assign full_next  = (gray_next == (w_q2_rptr ^ FULL_MASK));
  assign level_next = bin_next - rbin;

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rbin[i] = ^(w_q2_rptr >> i);
    end
  end

  // Flags are computed from the next pointer so they land on the same edge
  // that commits the write.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      w_bin       <= '0;
      w_ptr       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      w_level     <= '0;
    end else begin
      w_bin       <= bin_next;
      w_ptr       <= gray_next;
      full        <= full_next;
      almost_full <= (level_next >= AF_LEVEL);
      w_level     <= level_next;
    end
  end

  // A clear coinciding with a blocked write restarts the count at that event.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      overflow <= blocked;
      drop_cnt <= blocked ? DROP_ONE : '0;
    end else if (blocked) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_w_ptr_full.sv
// Directed and randomized checks of w_ptr_full against a counter-based
// reference model of the write side of the FIFO.
module tb_w_ptr_full;

  localparam int AW = 4;
  localparam int AF = 12;
  localparam int DW = 8;

  logic          w_clk = 1'b0;
  logic          w_rst_n;
  logic          w_en;
  logic [AW:0]   w_q2_rptr;
  logic          ovf_clr;
  logic [AW:0]   w_ptr;
  logic [AW-1:0] w_addr;
  logic          w_we;
  logic          full;
  logic          almost_full;
  logic [AW:0]   w_level;
  logic          overflow;
  logic [DW-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: total accepted writes and total reads as plain integers.
  int m_wcount = 0;
  int m_rcount = 0;
  int m_level  = 0;
  int m_drop   = 0;
  bit m_full   = 1'b0;
  bit m_af     = 1'b0;
  bit m_ovf    = 1'b0;
  bit m_known  = 1'b0;

  w_ptr_full #(.ADDR_WIDTH(AW), .AF_THRESH(AF), .DROP_W(DW)) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .w_en        (w_en),
    .w_q2_rptr   (w_q2_rptr),
    .ovf_clr     (ovf_clr),
    .w_ptr       (w_ptr),
    .w_addr      (w_addr),
    .w_we        (w_we),
    .full        (full),
    .almost_full (almost_full),
    .w_level     (w_level),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    bit acc;
    bit blk;
    if (!w_rst_n) begin
      m_wcount = 0;
      m_level  = 0;
      m_full   = 1'b0;
      m_af     = 1'b0;
      m_ovf    = 1'b0;
      m_drop   = 0;
      m_known  = 1'b1;
    end else begin
      acc = w_en && !m_full;
      blk = w_en && m_full;
      if (acc) m_wcount++;
      m_level = (((m_wcount - m_rcount) % 32) + 32) % 32;
      m_full  = (m_level == 16);
      m_af    = (m_level >= AF);
      if (ovf_clr) begin
        m_ovf  = blk;
        m_drop = blk ? 1 : 0;
      end else if (blk) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic checkOutput();
    chk("w_ptr",       w_ptr,       to_gray(m_wcount));
    chk("w_level",     w_level,     m_level);
    chk("full",        full,        m_full);
    chk("almost_full", almost_full, m_af);
    chk("overflow",    overflow,    m_ovf);
    chk("drop_cnt",    drop_cnt,    m_drop);
  endtask

  // Drive one cycle: combinational outputs are checked before the edge,
  // registered outputs 1 time unit after it.
  task automatic applyStimulus(input bit en, input int rc, input bit clr, input bit rst_n);
    w_en      = en;
    m_rcount  = rc;
    w_q2_rptr = to_gray(rc);
    ovf_clr   = clr;
    w_rst_n   = rst_n;
    #1;
    if (m_known) begin
      chk("w_we",   w_we,   en && !m_full);
      chk("w_addr", w_addr, m_wcount % 16);
    end
    @(posedge w_clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    int rc;
    bit en;
    w_en      = 1'b0;
    ovf_clr   = 1'b0;
    w_rst_n   = 1'b0;
    w_q2_rptr = '0;
    $display("[TB] starting w_ptr_full bench");

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    chk("idle_ptr",   w_ptr,       5'b00000);
    chk("idle_level", w_level,     0);
    chk("idle_full",  full,        0);
    chk("idle_af",    almost_full, 0);

    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 1);
    chk("burst_level", w_level, 7);
    applyStimulus(1, 0, 0, 0);
    chk("midrst_ptr",   w_ptr,    0);
    chk("midrst_level", w_level,  0);
    chk("midrst_addr",  w_addr,   0);
    chk("midrst_full",  full,     0);
    chk("midrst_drop",  drop_cnt, 0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 0, 1);
      if (i == 10) chk("af_below", almost_full, 0);
      if (i == 11) begin
        chk("af_rise",  almost_full, 1);
        chk("af_level", w_level,     12);
      end
      if (i == 14) chk("not_full_15", full, 0);
    end
    chk("full_ptr",   w_ptr,   5'b11000);
    chk("full_flag",  full,    1);
    chk("full_level", w_level, 16);

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1);
    chk("ovf_ptr",  w_ptr,    5'b11000);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 3);
    applyStimulus(0, 0, 1, 1);
    chk("clr_flag", overflow, 0);
    chk("clr_drop", drop_cnt, 0);

    applyStimulus(0, 4, 0, 1);
    chk("drain_full",  full,    0);
    chk("drain_level", w_level, 12);
    applyStimulus(1, 4, 0, 1);
    chk("refill_level", w_level, 13);
    chk("refill_ptr",   w_ptr,   5'b11001);

    for (int i = 0; i < 100; i++) begin
      applyStimulus(1, m_wcount + 1 - 3, 0, 1);
      chk("lap_level", w_level, 3);
      chk("lap_full",  full,    0);
    end

    for (int i = 0; i < 200; i++) begin
      en = ($urandom_range(0, 3) != 0);
      rc = m_rcount + int'($urandom_range(0, 2));
      if (rc > m_wcount) rc = m_wcount;
      applyStimulus(en, rc, ($urandom_range(0, 15) == 0), 1);
    end

    for (int i = 0; i < 40; i++) begin
      if (m_full) break;
      applyStimulus(1, m_rcount, 0, 1);
    end
    chk("refull", full, 1);
    for (int i = 0; i < 300; i++) applyStimulus(1, m_rcount, 0, 1);
    chk("sat_drop", drop_cnt, 255);
    chk("sat_ovf",  overflow, 1);
    applyStimulus(1, m_rcount, 1, 1);
    chk("clrblk_ovf",  overflow, 1);
    chk("clrblk_drop", drop_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
